// File: rtl/cmul_rr_arbiter_if.sv
// Request/response bundle for the shared sc16 complex multiplier.
// Port i owns bits [32*i+31:32*i] of each data bus and bit i of each control vector.
interface cmul_rr_arbiter_if #(
    parameter int NUM_PORTS = 4
);
    logic [32*NUM_PORTS-1:0] s_a_tdata;
    logic [32*NUM_PORTS-1:0] s_b_tdata;
    logic [NUM_PORTS-1:0]    s_conj;
    logic [NUM_PORTS-1:0]    s_tvalid;
    logic [NUM_PORTS-1:0]    s_tready;
    logic [32*NUM_PORTS-1:0] m_tdata;
    logic [NUM_PORTS-1:0]    m_tvalid;
    logic [NUM_PORTS-1:0]    m_tready;

    modport master (
        output s_a_tdata, s_b_tdata, s_conj, s_tvalid, m_tready,
        input  s_tready, m_tdata, m_tvalid
    );

    modport slave (
        input  s_a_tdata, s_b_tdata, s_conj, s_tvalid, m_tready,
        output s_tready, m_tdata, m_tvalid
    );
endinterface

// File: rtl/cmul_rr_arbiter.sv
// Round-robin shared 3-stage Q0.15 complex multiplier (a*b or a*conj(b)),
// one request in flight per port, result held per port until consumed.
module cmul_rr_arbiter #(
    parameter int NUM_PORTS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    cmul_rr_arbiter_if.slave bus
);
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    typedef logic [PW-1:0] tag_t;

    logic [1:0]              rst_sync_q, rst_sync_d;
    logic                    run;
    logic [NUM_PORTS-1:0]    busy_q, busy_d, eligible, grant;
    tag_t                    rr_ptr_q, rr_ptr_d, grant_idx;
    logic                    grant_any;
    int                      idx;

    logic [31:0]             a_sel, b_sel;
    logic                    conj_sel;
    logic signed [15:0]      ar, ai, br, bi;
    logic signed [16:0]      bi_eff;

    logic                    s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;
    tag_t                    s1_tag_q, s1_tag_d, s2_tag_q, s2_tag_d;
    logic signed [32:0]      s1_rr_q, s1_ii_q, s1_ri_q, s1_ir_q;
    logic signed [32:0]      s1_rr_d, s1_ii_d, s1_ri_d, s1_ir_d;
    logic signed [32:0]      s2_re_q, s2_im_q, s2_re_d, s2_im_d;

    logic [NUM_PORTS-1:0]    m_tvalid_q, m_tvalid_d;
    logic [32*NUM_PORTS-1:0] m_tdata_q, m_tdata_d;

    // Round half-ULP away from zero, then clip to the s16 range.
    function automatic logic [15:0] round_sat(input logic signed [32:0] s);
        logic signed [33:0] t;
        t = 34'(s) + (s[32] ? 34'sd16383 : 34'sd16384);
        t = t >>> 15;
        if (t > 34'sd32767)       return 16'h7FFF;
        else if (t < -34'sd32768) return 16'h8000;
        else                      return t[15:0];
    endfunction

    assign run = rst_sync_q[1];

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = 0;
        eligible  = bus.s_tvalid & ~busy_q;
        if (run) begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                idx = int'(rr_ptr_q) + k;
                if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
                if (!grant_any && eligible[idx]) begin
                    grant_any      = 1'b1;
                    grant[idx]     = 1'b1;
                    grant_idx      = tag_t'(idx);
                end
            end
        end
        rr_ptr_d = rr_ptr_q;
        if (grant_any) rr_ptr_d = (grant_idx == tag_t'(NUM_PORTS - 1)) ? '0 : grant_idx + 1'b1;
        busy_d     = (busy_q | grant) & ~(m_tvalid_q & bus.m_tready);
        rst_sync_d = {rst_sync_q[0], 1'b1};
    end

    always_comb begin
        a_sel    = bus.s_a_tdata[32*grant_idx +: 32];
        b_sel    = bus.s_b_tdata[32*grant_idx +: 32];
        conj_sel = bus.s_conj[grant_idx];
        ar       = signed'(a_sel[31:16]);
        ai       = signed'(a_sel[15:0]);
        br       = signed'(b_sel[31:16]);
        bi       = signed'(b_sel[15:0]);
        // 17 bits so that negating -32768 yields +32768 exactly.
        bi_eff   = conj_sel ? -17'(bi) : 17'(bi);
        s1_vld_d = grant_any;
        s1_tag_d = grant_idx;
        s1_rr_d  = 33'(ar) * 33'(br);
        s1_ii_d  = 33'(ai) * 33'(bi_eff);
        s1_ri_d  = 33'(ar) * 33'(bi_eff);
        s1_ir_d  = 33'(ai) * 33'(br);
        s2_vld_d = s1_vld_q;
        s2_tag_d = s1_tag_q;
        s2_re_d  = s1_rr_q - s1_ii_q;
        s2_im_d  = s1_ri_q + s1_ir_q;
    end

    always_comb begin
        m_tvalid_d = m_tvalid_q & ~bus.m_tready;
        m_tdata_d  = m_tdata_q;
        if (s2_vld_q) begin
            m_tvalid_d[s2_tag_q]           = 1'b1;
            m_tdata_d[32*s2_tag_q +: 32]   = {round_sat(s2_re_q), round_sat(s2_im_q)};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) begin
            rst_sync_q <= '0;
            busy_q     <= '0;
            rr_ptr_q   <= '0;
            s1_vld_q   <= 1'b0;
            s2_vld_q   <= 1'b0;
            s1_tag_q   <= '0;
            s2_tag_q   <= '0;
            m_tvalid_q <= '0;
            m_tdata_q  <= '0;
        end else begin
            rst_sync_q <= rst_sync_d;
            busy_q     <= busy_d;
            rr_ptr_q   <= rr_ptr_d;
            s1_vld_q   <= s1_vld_d;
            s2_vld_q   <= s2_vld_d;
            s1_tag_q   <= s1_tag_d;
            s2_tag_q   <= s2_tag_d;
            m_tvalid_q <= m_tvalid_d;
            m_tdata_q  <= m_tdata_d;
        end
    end

    // NOTE: pipeline data needs no reset; it is only observed alongside its reset valid bit.
    always_ff @(posedge clk) begin
        s1_rr_q <= s1_rr_d;
        s1_ii_q <= s1_ii_d;
        s1_ri_q <= s1_ri_d;
        s1_ir_q <= s1_ir_d;
        s2_re_q <= s2_re_d;
        s2_im_q <= s2_im_d;
    end

    assign bus.s_tready = grant;
    assign bus.m_tvalid = m_tvalid_q;
    assign bus.m_tdata  = m_tdata_q;
endmodule

// File: tb/tb_cmul_rr_arbiter.sv
// Directed bench for cmul_rr_arbiter: vector table for arithmetic, hand sequences
// for round-robin order, backpressure isolation and reset mid-operation.
module tb_cmul_rr_arbiter;
    localparam int N = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cmul_rr_arbiter_if #(.NUM_PORTS(N)) bus ();
    cmul_rr_arbiter #(.NUM_PORTS(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        int          port;
        logic [31:0] a;
        logic [31:0] b;
        logic        conj;
        logic [31:0] exp;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic clear_inputs();
        bus.s_a_tdata = '0;
        bus.s_b_tdata = '0;
        bus.s_conj    = '0;
        bus.s_tvalid  = '0;
        bus.m_tready  = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic run_vec(input int id, input vec_t v);
        logic [N-1:0] exp_g;
        int  lat;
        bit  got;
        exp_g = '0;
        exp_g[v.port] = 1'b1;
        @(negedge clk);
        bus.s_a_tdata[32*v.port +: 32] = v.a;
        bus.s_b_tdata[32*v.port +: 32] = v.b;
        bus.s_conj[v.port]             = v.conj;
        bus.s_tvalid                   = exp_g;
        bus.m_tready                   = '0;
        #1 check($sformatf("vec%0d grant", id), bus.s_tready, exp_g);
        @(negedge clk);
        bus.s_tvalid = '0;
        got = 1'b0;
        for (lat = 1; lat <= 8; lat++) begin
            if (lat > 1) @(negedge clk);
            #1;
            if (bus.m_tvalid[v.port]) begin
                got = 1'b1;
                break;
            end
        end
        check($sformatf("vec%0d latency", id), got ? lat : 0, 3);
        check($sformatf("vec%0d data", id), bus.m_tdata[32*v.port +: 32], v.exp);
        bus.m_tready[v.port] = 1'b1;
        @(negedge clk);
        #1 check($sformatf("vec%0d consumed", id), bus.m_tvalid[v.port], 1'b0);
        bus.m_tready = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[11];
        logic [N-1:0] exp_g;
        logic [31:0]  held;
        bit  held_seen, found;
        int  bad_regrant, bad_hold, early, stale;
        int  served[N];

        vecs[0]  = '{0, 32'h4000_0000, 32'h4000_0000, 1'b0, 32'h2000_0000};
        vecs[1]  = '{1, 32'h0001_0000, 32'h4000_0000, 1'b0, 32'h0001_0000};
        vecs[2]  = '{2, 32'hFFFF_0000, 32'h4000_0000, 1'b0, 32'hFFFF_0000};
        vecs[3]  = '{3, 32'h0001_0000, 32'h3FFF_0000, 1'b0, 32'h0000_0000};
        vecs[4]  = '{0, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h7FFF_0000};
        vecs[5]  = '{1, 32'h8000_8000, 32'h8000_8000, 1'b0, 32'h0000_7FFF};
        vecs[6]  = '{2, 32'h0000_4000, 32'h0000_4000, 1'b1, 32'h2000_0000};
        vecs[7]  = '{3, 32'h0000_4000, 32'h0000_4000, 1'b0, 32'hE000_0000};
        vecs[8]  = '{1, 32'h4000_2000, 32'h2000_4000, 1'b1, 32'h2000_E800};
        vecs[9]  = '{2, 32'h4000_2000, 32'h2000_4000, 1'b0, 32'h0000_2800};
        vecs[10] = '{0, 32'h7FFF_0000, 32'h0000_8000, 1'b1, 32'h0000_7FFF};

        // Reset state with requests pending.
        clear_inputs();
        bus.s_tvalid = '1;
        #12;
        check("reset s_tready", bus.s_tready, '0);
        check("reset m_tvalid", bus.m_tvalid, '0);
        check("reset m_tdata", bus.m_tdata, '0);
        do_reset();

        for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

        // Round-robin order with all ports requesting and always consuming.
        do_reset();
        for (int p = 0; p < N; p++) begin
            bus.s_a_tdata[32*p +: 32] = 32'h4000_0000;
            bus.s_b_tdata[32*p +: 32] = {16'(p * 16'h1000), 16'h0000};
        end
        bus.s_tvalid = '1;
        bus.m_tready = '1;
        for (int c = 0; c < 12; c++) begin
            #1;
            exp_g = '0;
            exp_g[c % N] = 1'b1;
            check($sformatf("rr grant c%0d", c), bus.s_tready, exp_g);
            if (c >= 3) begin
                exp_g = '0;
                exp_g[(c - 3) % N] = 1'b1;
                check($sformatf("rr m_tvalid c%0d", c), bus.m_tvalid, exp_g);
                check($sformatf("rr data c%0d", c), bus.m_tdata[32*((c-3)%N) +: 32],
                      {16'(((c - 3) % N) * 16'h0800), 16'h0000});
            end
            @(negedge clk);
        end

        // Backpressure on port 1 only.
        do_reset();
        bus.s_a_tdata = {N{32'h4000_0000}};
        bus.s_b_tdata = {N{32'h2000_0000}};
        bus.s_tvalid  = '1;
        bus.m_tready  = 4'b1101;
        held_seen = 1'b0; held = '0; bad_regrant = 0; bad_hold = 0;
        for (int p = 0; p < N; p++) served[p] = 0;
        for (int c = 0; c < 24; c++) begin
            #1;
            if (held_seen) begin
                if (bus.s_tready[1]) bad_regrant++;
                if (!bus.m_tvalid[1] || bus.m_tdata[63:32] !== held) bad_hold++;
                for (int p = 0; p < N; p++) if (bus.s_tready[p]) served[p]++;
            end else if (bus.m_tvalid[1]) begin
                held_seen = 1'b1;
                held      = bus.m_tdata[63:32];
            end
            @(negedge clk);
        end
        check("bp result appeared", held_seen, 1'b1);
        check("bp held value", held, 32'h1000_0000);
        check("bp no regrant", bad_regrant, 0);
        check("bp held stable", bad_hold, 0);
        check("bp port0 served", served[0] >= 2, 1'b1);
        check("bp port2 served", served[2] >= 2, 1'b1);
        check("bp port3 served", served[3] >= 2, 1'b1);
        bus.m_tready[1] = 1'b1;
        #1;
        check("bp release no same-cycle grant", bus.s_tready[1], 1'b0);
        found = 1'b0;
        for (int k = 0; k < 6 && !found; k++) begin
            @(negedge clk);
            #1 if (bus.s_tready[1]) found = 1'b1;
        end
        check("bp port1 regranted", found, 1'b1);

        // Reset with three operations in flight.
        do_reset();
        bus.s_a_tdata = {N{32'h4000_0000}};
        bus.s_b_tdata = {N{32'h4000_0000}};
        bus.s_tvalid  = 4'b0111;
        bus.m_tready  = '0;
        repeat (3) @(posedge clk);
        #2;
        check("mid pre-reset m_tvalid", bus.m_tvalid, 4'b0001);
        bus.s_tvalid = '1;
        rst_n = 1'b0;
        #1;
        check("mid reset m_tvalid", bus.m_tvalid, '0);
        check("mid reset s_tready", bus.s_tready, '0);
        check("mid reset m_tdata", bus.m_tdata, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        early = 0; stale = 0;
        for (int k = 0; k < 5; k++) begin
            #1;
            if (bus.m_tvalid !== '0) stale++;
            if (k < 2 && bus.s_tready !== '0) early++;
            if (k == 2) check("mid first grant port0", bus.s_tready, 4'b0001);
            @(negedge clk);
        end
        check("mid no early grant", early, 0);
        check("mid no stale result", stale, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
